hit_scheduler: RTL and testbench

Frame-rate controller that shares one laser-versus-enemy collision comparator across all enemy slots. On each frame tick it scans the enemy position store slot by slot and retires the first enemy the active user laser overlaps. It owns the per-slot alive and explosion state, and issues one-cycle kill and score pulses to the laser and score logic. It sits between the enemy position RAM, the user laser controller and the sprite/score datapath.

---
 rtl/hit_pkg.sv | 30 +++
 rtl/hit_scheduler_explode_timer.sv | 24 ++
 rtl/hit_scheduler.sv | 135 +++++++++++++
 tb/tb_hit_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hit_pkg.sv
// Shared collision types and helpers for the laser/enemy hit scheduler.
package hit_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, HIT, TICK} state_t;

  localparam int ENEMY_SIZE = 30;
  localparam int LASER_W    = 20;
  localparam int LASER_H    = 49;
  localparam int TMR_W      = 8;

  // Inclusive box overlap in 11-bit unsigned space so x+size never wraps.
  function automatic logic aabb_overlap(
    input logic [9:0]  lx,
    input logic [9:0]  ly,
    input logic [9:0]  ex,
    input logic [9:0]  ey,
    input logic [10:0] esz,
    input logic [10:0] lw,
    input logic [10:0] lh
  );
    logic [10:0] lx11, ly11, ex11, ey11;
    lx11 = {1'b0, lx};
    ly11 = {1'b0, ly};
    ex11 = {1'b0, ex};
    ey11 = {1'b0, ey};
    return (lx11 <= ex11 + esz) && (lx11 + lw >= ex11) &&
           (ly11 <= ey11 + esz) && (ly11 + lh >= ey11);
  endfunction

endpackage

// File: rtl/hit_scheduler_explode_timer.sv
// Per-slot explosion down-counter: load wins over tick, active while nonzero.
module explode_timer
  import hit_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_active
);

  logic [TMR_W-1:0] r_cnt;

  // Load on hit, otherwise count down once per frame tick until empty.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                       r_cnt <= '0;
    else if (i_load)                 r_cnt <= i_load_val;
    else if (i_tick && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_active = (r_cnt != '0);

endmodule

// File: rtl/hit_scheduler.sv
// Frame-rate collision scheduler: one shared AABB comparator walks all enemy
// slots per frame, retires the first enemy the laser overlaps, and owns the
// alive / explosion state per slot.
module hit_scheduler #(
  parameter int NUM_ENEMIES    = 8,
  parameter int ENEMY_SIZE     = hit_pkg::ENEMY_SIZE,
  parameter int LASER_W        = hit_pkg::LASER_W,
  parameter int LASER_H        = hit_pkg::LASER_H,
  parameter int EXPLODE_FRAMES = 16
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_start,
  input  logic                           laser_active,
  input  logic [9:0]                     laser_x,
  input  logic [9:0]                     laser_y,
  output logic [$clog2(NUM_ENEMIES)-1:0] enemy_idx,
  input  logic [9:0]                     enemy_x,
  input  logic [9:0]                     enemy_y,
  input  logic                           spawn_req,
  input  logic [$clog2(NUM_ENEMIES)-1:0] spawn_idx,
  output logic [NUM_ENEMIES-1:0]         alive_mask,
  output logic [NUM_ENEMIES-1:0]         exploding_mask,
  output logic                           laser_kill,
  output logic                           score_inc,
  output logic [$clog2(NUM_ENEMIES)-1:0] hit_idx,
  output logic                           busy
);

  localparam int IW = $clog2(NUM_ENEMIES);

  hit_pkg::state_t r_state, w_next;

  logic [IW-1:0]          r_enemy_idx, r_cmp_idx, r_hit_idx;
  logic                   r_cmp_vld, r_hit_frame;
  logic [9:0]             r_lx, r_ly;
  logic [NUM_ENEMIES-1:0] r_alive, w_active;
  logic                   w_qual, w_last, w_in_hit;

  // Position data for r_cmp_idx arrives this cycle; only alive slots count.
  assign w_qual   = r_cmp_vld && r_alive[r_cmp_idx] &&
                    hit_pkg::aabb_overlap(r_lx, r_ly, enemy_x, enemy_y,
                                          11'(ENEMY_SIZE), 11'(LASER_W), 11'(LASER_H));
  assign w_last   = (r_cmp_idx == IW'(NUM_ENEMIES - 1));
  assign w_in_hit = (r_state == hit_pkg::HIT);

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= hit_pkg::IDLE;
    else       r_state <= w_next;
  end

  // Next-state: frame_start outside IDLE is simply not looked at.
  always_comb begin
    w_next = r_state;
    case (r_state)
      hit_pkg::IDLE: if (frame_start) w_next = laser_active ? hit_pkg::SCAN : hit_pkg::TICK;
      hit_pkg::SCAN: begin
        if (w_qual)                  w_next = hit_pkg::HIT;
        else if (r_cmp_vld && w_last) w_next = hit_pkg::TICK;
      end
      hit_pkg::HIT:  w_next = hit_pkg::TICK;
      hit_pkg::TICK: w_next = hit_pkg::IDLE;
      default:       w_next = hit_pkg::IDLE;
    endcase
  end

  // Scan pipeline: address slot k while comparing slot k-1; capture laser copy.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_lx        <= '0;
      r_ly        <= '0;
      r_enemy_idx <= '0;
      r_cmp_idx   <= '0;
      r_cmp_vld   <= 1'b0;
      r_hit_idx   <= '0;
      r_hit_frame <= 1'b0;
    end else begin
      case (r_state)
        hit_pkg::IDLE: if (frame_start) begin
          r_lx        <= laser_x;
          r_ly        <= laser_y;
          r_enemy_idx <= '0;
          r_cmp_vld   <= 1'b0;
        end
        hit_pkg::SCAN: begin
          r_enemy_idx <= r_enemy_idx + 1'b1;
          r_cmp_idx   <= r_enemy_idx;
          r_cmp_vld   <= 1'b1;
          if (w_qual) r_hit_idx <= r_cmp_idx;
        end
        hit_pkg::HIT:  r_hit_frame <= 1'b1;
        hit_pkg::TICK: begin
          r_hit_frame <= 1'b0;
          r_enemy_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  // Alive bits: spawn revives an idle slot; a HIT on the same slot overrides it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_alive <= '1;
    end else begin
      if (spawn_req && !r_alive[spawn_idx] && !w_active[spawn_idx] &&
          !(w_in_hit && spawn_idx == r_hit_idx))
        r_alive[spawn_idx] <= 1'b1;
      if (w_in_hit)
        r_alive[r_hit_idx] <= 1'b0;
    end
  end

  // One explosion timer per slot; the slot hit this frame skips this TICK.
  for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_tmr
    explode_timer u_tmr (
      .Clk        (Clk),
      .Reset      (Reset),
      .i_load     (w_in_hit && r_hit_idx == IW'(g)),
      .i_load_val (hit_pkg::TMR_W'(EXPLODE_FRAMES)),
      .i_tick     (r_state == hit_pkg::TICK && !(r_hit_frame && r_hit_idx == IW'(g))),
      .o_active   (w_active[g])
    );
  end

  assign enemy_idx      = r_enemy_idx;
  assign alive_mask     = r_alive;
  assign exploding_mask = w_active;
  assign laser_kill     = w_in_hit;
  assign score_inc      = w_in_hit;
  assign hit_idx        = r_hit_idx;
  assign busy           = (r_state != hit_pkg::IDLE);

endmodule

// File: tb/tb_hit_scheduler.sv
// Bench for hit_scheduler: table of single-frame vectors plus hand sequences
// for explosion expiry, mid-scan reset and frame_start while busy.
module tb_hit_scheduler;

  localparam int N = 8;

  logic       Clk, Reset, frame_start, laser_active, spawn_req;
  logic [9:0] laser_x, laser_y, enemy_x, enemy_y;
  logic [2:0] enemy_idx, spawn_idx, hit_idx;
  logic [N-1:0] alive_mask, exploding_mask;
  logic       laser_kill, score_inc, busy;

  logic [9:0] ram_x [N];
  logic [9:0] ram_y [N];

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  hit_scheduler #(.NUM_ENEMIES(N)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .laser_active(laser_active),
    .laser_x(laser_x), .laser_y(laser_y), .enemy_idx(enemy_idx),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .spawn_req(spawn_req), .spawn_idx(spawn_idx),
    .alive_mask(alive_mask), .exploding_mask(exploding_mask), .laser_kill(laser_kill),
    .score_inc(score_inc), .hit_idx(hit_idx), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Position store: one-cycle read latency.
  always @(posedge Clk) begin
    enemy_x <= ram_x[enemy_idx];
    enemy_y <= ram_y[enemy_idx];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every kill pulse must match the next expected slot.
  always @(negedge Clk) begin
    if (!Reset && (laser_kill || score_inc)) begin
      chk("pulse_coincide", {31'b0, score_inc}, {31'b0, laser_kill});
      if (laser_kill) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_kill: got pulse hit_idx=%0d expected none", hit_idx);
        end else begin
          chk("sb_hit_idx", {29'b0, hit_idx}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; step(); step(); Reset = 1'b0; step();
  endtask

  task automatic set_far();
    for (int i = 0; i < N; i++) begin ram_x[i] = 10'd500; ram_y[i] = 10'd0; end
  endtask

  task automatic start_frame();
    frame_start = 1'b1; step(); frame_start = 1'b0;
  endtask

  task automatic run_busy(output int n);
    n = 0;
    while (busy && n < 200) begin n++; step(); end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL busy_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic spawn(input int s);
    spawn_req = 1'b1; spawn_idx = 3'(s); step(); spawn_req = 1'b0;
  endtask

  typedef struct {
    logic la;
    int lx, ly, sa, xa, ya, sb, xb, yb, exp;
  } vec_t;

  vec_t tv[10];
  int n, first, highs, bsum;
  logic [N-1:0] m;

  initial begin
    Reset = 1'b0; frame_start = 1'b0; laser_active = 1'b0; spawn_req = 1'b0;
    spawn_idx = '0; laser_x = '0; laser_y = '0;
    set_far();

    tv[0] = '{1'b0, 100, 200, 3, 110, 230, 3, 110, 230, -1};
    tv[1] = '{1'b1, 100, 200, 3, 110, 230, 3, 110, 230,  3};
    tv[2] = '{1'b1, 100, 200, 2, 110, 230, 5, 110, 230,  2};
    tv[3] = '{1'b1,   0,   0, 0,  20,  49, 0,  20,  49,  0};
    tv[4] = '{1'b1,   0,   0, 4,  21,   0, 4,  21,   0, -1};
    tv[5] = '{1'b1,   0,   0, 6,   0,  50, 6,   0,  50, -1};
    tv[6] = '{1'b1, 1000, 1000, 7, 1015, 1015, 7, 1015, 1015, 7};
    tv[7] = '{1'b1, 1010, 1010, 1, 0, 0, 1, 0, 0, -1};
    tv[8] = '{1'b1,  30,  30, 0,   0,   0, 0,   0,   0,  0};
    tv[9] = '{1'b1,  31,   0, 2,   0,   0, 2,   0,   0, -1};

    // Reset state
    do_reset();
    chk("rst_alive", {24'b0, alive_mask}, 32'hFF);
    chk("rst_expl",  {24'b0, exploding_mask}, 32'h0);
    chk("rst_busy",  {31'b0, busy}, 32'h0);
    chk("rst_kill",  {31'b0, laser_kill}, 32'h0);
    chk("rst_eidx",  {29'b0, enemy_idx}, 32'h0);
    chk("rst_hidx",  {29'b0, hit_idx}, 32'h0);

    // Table vectors, each from a fresh reset
    for (int i = 0; i < 10; i++) begin
      do_reset();
      set_far();
      ram_x[tv[i].sa] = 10'(tv[i].xa); ram_y[tv[i].sa] = 10'(tv[i].ya);
      ram_x[tv[i].sb] = 10'(tv[i].xb); ram_y[tv[i].sb] = 10'(tv[i].yb);
      laser_active = tv[i].la; laser_x = 10'(tv[i].lx); laser_y = 10'(tv[i].ly);
      if (tv[i].exp >= 0) exp_q.push_back(tv[i].exp);
      start_frame();
      run_busy(n);
      m = '0;
      if (tv[i].exp >= 0) m[tv[i].exp] = 1'b1;
      chk($sformatf("v%0d_busy_cycles", i), n,
          (tv[i].exp >= 0) ? tv[i].exp + 4 : (tv[i].la ? N + 2 : 1));
      chk($sformatf("v%0d_alive", i), {24'b0, alive_mask}, {24'b0, ~m});
      chk($sformatf("v%0d_expl", i), {24'b0, exploding_mask}, {24'b0, m});
      chk($sformatf("v%0d_hidx", i), {29'b0, hit_idx}, (tv[i].exp >= 0) ? tv[i].exp : 0);
    end

    // Single hit timing, then explosion expiry and spawn gating
    do_reset(); set_far();
    ram_x[3] = 10'd110; ram_y[3] = 10'd230;
    laser_active = 1'b1; laser_x = 10'd100; laser_y = 10'd200;
    exp_q.push_back(3);
    start_frame();
    first = 0; highs = 0;
    for (int c = 1; c <= 10; c++) begin
      if (laser_kill) begin highs++; if (first == 0) first = c; end
      step();
    end
    chk("hit_cycle", first, 6);
    chk("pulse_width", highs, 1);
    chk("hit_alive", {24'b0, alive_mask}, 32'hF7);
    chk("hit_expl",  {24'b0, exploding_mask}, 32'h08);
    laser_active = 1'b0;
    for (int f = 0; f < 15; f++) begin start_frame(); run_busy(n); end
    chk("expl_15", {24'b0, exploding_mask}, 32'h08);
    spawn(3);
    chk("spawn_rejected", {24'b0, alive_mask}, 32'hF7);
    start_frame(); run_busy(n);
    chk("expl_16", {24'b0, exploding_mask}, 32'h00);
    spawn(3);
    chk("spawn_accepted", {24'b0, alive_mask}, 32'hFF);

    // Reset asserted at cycle 4 of a scan that would hit slot 3
    do_reset(); set_far();
    ram_x[3] = 10'd110; ram_y[3] = 10'd230;
    laser_active = 1'b1; laser_x = 10'd100; laser_y = 10'd200;
    start_frame();
    step(); step(); step();
    Reset = 1'b1; #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_eidx", {29'b0, enemy_idx}, 32'h0);
    chk("mid_rst_alive", {24'b0, alive_mask}, 32'hFF);
    chk("mid_rst_kill", {31'b0, laser_kill}, 32'h0);
    step(); Reset = 1'b0;
    highs = 0;
    for (int c = 0; c < 12; c++) begin if (laser_kill) highs++; step(); end
    chk("mid_rst_no_pulse", highs, 0);

    // frame_start during a scan is dropped, not queued
    do_reset(); set_far();
    laser_active = 1'b1; laser_x = 10'd100; laser_y = 10'd200;
    start_frame();
    step(); step();
    start_frame();
    run_busy(n);
    chk("busy_ignore_total", n + 3, N + 2);
    bsum = 0;
    for (int c = 0; c < 6; c++) begin if (busy) bsum++; step(); end
    chk("busy_no_requeue", bsum, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
